demux_collector_4: RTL

Downstream stage of the 4-way mux/demux fabric. Accepts the time-multiplexed lane stream, one `WIDTH`-bit beat per cycle tagged with its 2-bit select. Writes each beat into the slot its select names and, once all four slots are filled, presents the assembled `4*WIDTH` bundle on a valid/ready output. Catches out-of-order and duplicate selects so the upstream select counter can be checked in-system.

---
 rtl/mux_demux_pkg.sv | 12 +
 rtl/counter.sv | 34 +++
 rtl/demux_collector_4.sv | 111 +++++++++++
 3 files changed

// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 4-way mux/demux fabric.
package mux_demux_pkg;

    localparam int unsigned SEL_W     = 2;
    localparam int unsigned NUM_SLOTS = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collect_state_t;

endpackage : mux_demux_pkg

// File: rtl/counter.sv
// Free-running up counter with synchronous clear and count enable; wraps at 2**WIDTH.
module counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : counter

// File: rtl/demux_collector_4.sv
// Reassembles four select-tagged lane beats into one bundle on a valid/ready output,
// flagging out-of-order and duplicate selects as one-cycle error pulses.
module demux_collector_4 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [1:0]                 in_sel,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [NUM_SLOTS*WIDTH-1:0] out_data,
    input  logic                       out_ready,
    output logic [NUM_SLOTS-1:0]       slot_mask,
    output logic                       err_order,
    output logic                       err_dup
);

    import mux_demux_pkg::*;

    collect_state_t       state_q, state_d;
    logic [WIDTH-1:0]     slot_q [NUM_SLOTS];
    logic [WIDTH-1:0]     slot_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] mask_q, mask_d;
    logic                 err_order_q, err_order_d;
    logic                 err_dup_q, err_dup_d;
    logic [SEL_W-1:0]     exp_idx;
    logic                 accept;
    logic                 handoff;

    counter #(
        .WIDTH(SEL_W)
    ) u_exp_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (handoff),
        .en   (accept),
        .count(exp_idx)
    );

    always_comb begin
        in_ready  = rst && (state_q == COLLECT);
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready;
        handoff   = out_valid && out_ready;

        state_d     = state_q;
        mask_d      = mask_q;
        slot_d      = slot_q;
        err_order_d = 1'b0;
        err_dup_d   = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    // Duplicates still overwrite; the mask bit is simply already set.
                    slot_d[in_sel] = in_data;
                    mask_d[in_sel] = 1'b1;
                    err_order_d    = (in_sel != exp_idx);
                    err_dup_d      = mask_q[in_sel];
                    if (&mask_d) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (handoff) begin
                    mask_d  = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            err_order_q <= 1'b0;
            err_dup_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            err_order_q <= err_order_d;
            err_dup_q   <= err_dup_d;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            out_data[i*WIDTH +: WIDTH] = slot_q[i];
        end
    end

    assign slot_mask = mask_q;
    assign err_order = err_order_q;
    assign err_dup   = err_dup_q;

endmodule : demux_collector_4
